// File: rtl/ceres_param.sv
// Shared types and default constants for the ceres front end.
package ceres_param;

  localparam int unsigned FQ_XLEN  = 32;
  localparam int unsigned FQ_DEPTH = 4;

  typedef enum logic [2:0] {
    NO_EXCEPTION,
    INSTR_MISALIGNED,
    INSTR_ACCESS_FAULT,
    ILLEGAL_INSTRUCTION,
    BREAKPOINT
  } exc_type_e;

  typedef enum logic [2:0] {
    INSTR_ALU,
    INSTR_LOAD,
    INSTR_STORE,
    INSTR_BRANCH,
    INSTR_JUMP,
    INSTR_SYSTEM
  } instr_type_e;

  typedef struct packed {
    logic               taken;
    logic [FQ_XLEN-1:0] target;
  } predict_info_t;

  typedef struct packed {
    logic [FQ_XLEN-1:0] pc;
    logic [FQ_XLEN-1:0] pc_incr;
    logic [FQ_XLEN-1:0] inst;
    instr_type_e        instr_type;
    exc_type_e          exc_type;
    predict_info_t      spec;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch-to-decode queue: circular buffer with flush and an exception fence that
// blocks further enqueues until a faulting entry has been handed to decode.
module fetch_queue
  import ceres_param::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH,
  parameter int unsigned XLEN  = FQ_XLEN
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     enq_valid_i,
  output logic                     enq_ready_o,
  input  fq_entry_t                enq_entry_i,
  output logic                     deq_valid_o,
  input  logic                     deq_ready_i,
  output fq_entry_t                deq_entry_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     exc_fence_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fetch_queue: DEPTH must be a power of two and at least 2");
  end
  if (XLEN != FQ_XLEN) begin : g_bad_xlen
    $error("fetch_queue: XLEN must match the fq_entry_t field width");
  end

  fq_entry_t       r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_exc_fence;

  logic            w_enq;
  logic            w_deq;
  logic            w_enq_exc;

  // Handshakes are forced low while reset is held so nothing is advertised.
  assign enq_ready_o = rst_ni && (r_count < CW'(DEPTH)) && !r_exc_fence && !flush_i;
  assign deq_valid_o = rst_ni && (r_count != '0) && !flush_i;
  assign deq_entry_o = r_mem[r_rd_ptr];
  assign count_o     = r_count;
  assign exc_fence_o = r_exc_fence;

  assign w_enq     = enq_valid_i && enq_ready_o;
  assign w_deq     = deq_valid_o && deq_ready_i;
  assign w_enq_exc = enq_entry_i.exc_type != NO_EXCEPTION;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_exc_fence <= 1'b0;
    end else if (flush_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_exc_fence <= 1'b0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_deq) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // Enqueue stalls once the fence is up, so the faulting entry is always the
      // last one queued: it leaves when the queue drains from one entry.
      if (w_enq && w_enq_exc) begin
        r_exc_fence <= 1'b1;
      end else if (w_deq && (r_count == CW'(1))) begin
        r_exc_fence <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wr_ptr] <= enq_entry_i;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries; power of two, at least 2.
REQ-002 SHALL have parameter XLEN, default 32, PC/instruction width.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk_i, input, 1 bit, the single clock.
REQ-005 SHALL have port rst_ni, input, 1 bit, async active-low reset.
REQ-006 SHALL have port flush_i, input, 1 bit, discard all queued entries.
REQ-007 SHALL have port enq_valid_i, input, 1 bit, fetch offers an entry.
REQ-008 SHALL have port enq_ready_o, output, 1 bit, queue accepts an entry.
REQ-009 SHALL have port enq_entry_i, input, fq_entry_t, fields {pc, pc_incr, inst, instr_type, exc_type, spec}.
REQ-010 SHALL have port deq_valid_o, output, 1 bit, head entry valid for decode.
REQ-011 SHALL have port deq_ready_i, input, 1 bit, decode consumes head.
REQ-012 SHALL have port deq_entry_o, output, fq_entry_t, head entry.
REQ-013 SHALL have port count_o, output, $clog2(DEPTH)+1 bits, current occupancy.
REQ-014 SHALL have port exc_fence_o, output, 1 bit, an exception entry is queued.

Function
REQ-015 SHALL enqueue on a clock edge iff enq_valid_i && enq_ready_o; SHALL dequeue iff deq_valid_o && deq_ready_i.
REQ-016 SHALL drive enq_ready_o = (count < DEPTH) && !exc_fence && !flush_i; no same-cycle space reuse when full.
REQ-017 SHALL drive deq_valid_o = (count != 0) && !flush_i; deq_entry_o SHALL be storage[rd_ptr], combinational from registers.
REQ-018 SHALL give enqueue-to-dequeue latency of exactly 1 cycle; no combinational enq-to-deq bypass.
REQ-019 SHALL hold deq_entry_o stable while deq_valid_o && !deq_ready_i.
REQ-020 SHALL advance wr_ptr/rd_ptr modulo DEPTH (wrap DEPTH-1 -> 0); count +1 on enq only, -1 on deq only, unchanged on both.
REQ-021 SHALL set exc_fence when an entry with exc_type != NO_EXCEPTION is enqueued; SHALL clear it on the edge that dequeues that entry.
REQ-022 SHALL, on flush_i, reset pointers, count and exc_fence to 0 at the next edge; enq/deq offered in that cycle are discarded.
REQ-023 SHALL, with simultaneous enq and deq at count 0, never occur (deq_valid_o low); at count DEPTH only deq SHALL take effect.
REQ-024 SHALL not modify storage contents except at wr_ptr on enqueue.

Reset
REQ-025 SHALL, while rst_ni low, clear wr_ptr, rd_ptr, count, exc_fence to 0 asynchronously; enq_ready_o=0, deq_valid_o=0, count_o=0, exc_fence_o=0.
REQ-026 SHALL assert enq_ready_o in the first cycle after rst_ni deasserts; storage content need not be reset.
REQ-027 SHALL abandon any in-progress transfer on mid-operation reset; no entry survives.

Structure
REQ-028 SHALL define fq_entry_t and the default FQ_DEPTH constant in ceres_param, reusing predict_info_t, exc_type_e, instr_type_e.
REQ-029 SHALL be implemented as one module without sub-modules; storage is a register array of fq_entry_t.
REQ-030 SHALL sit between fetch outputs and decode inputs; fetch stall SHALL derive from !enq_ready_o.

Verification
REQ-031 Reset then enq pc=0x8000_0000,0x8000_0004 on consecutive cycles, deq_ready_i=1 -> deq_valid_o rises one cycle after first enq, pcs dequeued in order, count_o peaks at 1.
REQ-032 deq_ready_i=0, enqueue 5 entries -> 4 accepted, enq_ready_o=0 with count_o=4; one dequeue -> enq_ready_o=1 next cycle.
REQ-033 Fill 4, drain 3, enqueue 3 more -> pointers wrap, 4 dequeued pcs match enqueue order exactly.
REQ-034 Enqueue entry with exc_type=ILLEGAL_INSTRUCTION at count 1 -> exc_fence_o=1, enq_ready_o=0 until that entry dequeues, then 1.
REQ-035 Queue with 3 entries, flush_i for one cycle with enq_valid_i=1 -> count_o=0, deq_valid_o=0 next cycle, flushed entry never dequeued.
REQ-036 Assert rst_ni=0 asynchronously mid-stream with count 2 -> outputs cleared before next clock edge, count_o=0.
